// File: rtl/lcd_value_feeder.sv
// Paces 18-bit values from a small FIFO into the 2x16 LCD driver: one reset
// pulse and init wait after reset, then one write strobe per render window.
module lcd_value_feeder #(
  parameter int DEPTH        = 4,
  parameter int INIT_CYCLES  = 24,
  parameter int WRITE_CYCLES = 160,
  parameter int CNT_W        = 8,
  parameter int DATA_W       = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     push_ready,
  input  logic                     dedup_en,
  output logic                     lcd_rst,
  output logic                     lcd_write,
  output logic [DATA_W-1:0]        lcd_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]      FULL_LVL   = (PW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_CYCLES - 1);

  localparam logic [2:0] INIT_RST  = 3'd0;
  localparam logic [2:0] INIT_WAIT = 3'd1;
  localparam logic [2:0] IDLE      = 3'd2;
  localparam logic [2:0] ISSUE     = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [CNT_W-1:0]  holdCnt;
  logic [DATA_W-1:0] lastValue;
  logic              lastValid;
  logic [DATA_W-1:0] head;
  logic              doPush;
  logic              doPop;
  logic              skipHead;

  assign push_ready = !rst && (level != FULL_LVL);
  assign head       = mem[rdPtr];
  assign doPush     = push_valid && push_ready;
  assign doPop      = (state == IDLE) && (level != '0);
  // A repeated head is consumed silently so the display is not redrawn.
  assign skipHead   = dedup_en && lastValid && (head == lastValue);
  assign busy       = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr] <= push_data;
    if (!rst && doPop && !skipHead)
      lastValue <= head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_RST;
      wrPtr     <= '0;
      rdPtr     <= '0;
      level     <= '0;
      holdCnt   <= '0;
      lcd_rst   <= 1'b0;
      lcd_write <= 1'b0;
      lcd_data  <= '0;
      lastValid <= 1'b0;
    end else begin
      lcd_rst   <= 1'b0;
      lcd_write <= 1'b0;
      if (doPush)
        wrPtr <= wrPtr + PW'(1);
      if (doPop)
        rdPtr <= rdPtr + PW'(1);
      if (doPush && !doPop)
        level <= level + (PW+1)'(1);
      else if (!doPush && doPop)
        level <= level - (PW+1)'(1);

      case (state)
        INIT_RST: begin
          lcd_rst <= 1'b1;
          holdCnt <= INIT_LOAD;
          state   <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (holdCnt == '0)
            state <= IDLE;
          else
            holdCnt <= holdCnt - CNT_W'(1);
        end
        IDLE: begin
          if (doPop && !skipHead) begin
            lcd_data  <= head;
            lastValid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Strobe is registered, so it appears while the FSM is already in HOLD.
          lcd_write <= 1'b1;
          holdCnt   <= WRITE_LOAD;
          state     <= HOLD;
        end
        HOLD: begin
          if (holdCnt == '0)
            state <= IDLE;
          else
            holdCnt <= holdCnt - CNT_W'(1);
        end
        default: state <= INIT_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_value_feeder.sv
// Directed bench for lcd_value_feeder: reset/init, single write, burst pacing,
// dedup, mid-operation reset and full-FIFO back-pressure.
module tb_lcd_value_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic [17:0] push_data;
  logic        push_ready;
  logic        dedup_en;
  logic        lcd_rst;
  logic        lcd_write;
  logic [17:0] lcd_data;
  logic        busy;
  logic [2:0]  level;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int wrCyc[$];
  logic [17:0] wrData[$];
  int rstPulses = 0;
  int overlap = 0;

  lcd_value_feeder dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .dedup_en(dedup_en), .lcd_rst(lcd_rst),
    .lcd_write(lcd_write), .lcd_data(lcd_data), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lcd_write) begin
      wrCyc.push_back(cyc);
      wrData.push_back(lcd_data);
    end
    if (lcd_rst) rstPulses++;
    if (lcd_rst && lcd_write) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1; push_valid = 1'b0; push_data = '0; dedup_en = 1'b0;
    tick; tick;
    vecs++; if (lcd_rst !== 1'b0) begin errs++; $display("FAIL rst_lcd_rst: got %b expected 0", lcd_rst); end
    vecs++; if (lcd_write !== 1'b0) begin errs++; $display("FAIL rst_lcd_write: got %b expected 0", lcd_write); end
    vecs++; if (level !== 3'd0) begin errs++; $display("FAIL rst_level: got %0d expected 0", level); end
    vecs++; if (push_ready !== 1'b0) begin errs++; $display("FAIL rst_push_ready: got %b expected 0", push_ready); end
    vecs++; if (lcd_data !== 18'h0) begin errs++; $display("FAIL rst_lcd_data: got %h expected 0", lcd_data); end
    rst = 1'b0;
    tick;
    vecs++; if (lcd_rst !== 1'b1) begin errs++; $display("FAIL init_pulse_hi: got %b expected 1", lcd_rst); end
    tick;
    vecs++; if (lcd_rst !== 1'b0) begin errs++; $display("FAIL init_pulse_lo: got %b expected 0", lcd_rst); end
    bad = 0;
    repeat (22) begin
      tick;
      if (busy !== 1'b1 || lcd_write !== 1'b0) bad++;
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL init_wait_busy: got %0d bad cycles expected 0", bad); end
    tick;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL init_done_busy: got %b expected 0", busy); end
    vecs++; if (wrCyc.size() != 0) begin errs++; $display("FAIL init_no_write: got %0d writes expected 0", wrCyc.size()); end
    vecs++; if (rstPulses != 1) begin errs++; $display("FAIL init_pulse_count: got %0d expected 1", rstPulses); end
  endtask

  task automatic test_single;
    int bad;
    push_valid = 1'b1; push_data = 18'h2A5C5;
    tick;
    push_valid = 1'b0;
    vecs++; if (level !== 3'd1) begin errs++; $display("FAIL single_level1: got %0d expected 1", level); end
    tick;
    vecs++; if (lcd_write !== 1'b0) begin errs++; $display("FAIL single_early_write: got %b expected 0", lcd_write); end
    vecs++; if (level !== 3'd0) begin errs++; $display("FAIL single_level0: got %0d expected 0", level); end
    tick;
    vecs++; if (lcd_write !== 1'b1) begin errs++; $display("FAIL single_write: got %b expected 1", lcd_write); end
    vecs++; if (lcd_data !== 18'h2A5C5) begin errs++; $display("FAIL single_data: got %h expected 2a5c5", lcd_data); end
    bad = 0;
    repeat (159) begin
      tick;
      if (lcd_data !== 18'h2A5C5 || lcd_write !== 1'b0 || busy !== 1'b1) bad++;
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL single_hold: got %0d bad cycles expected 0", bad); end
    tick;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_burst;
    int base, idx, n, firstFull, fullLevel;
    logic rdy;
    base = wrCyc.size();
    idx = 0; n = 0; firstFull = -1; fullLevel = -1;
    push_valid = 1'b1; push_data = 18'd1;
    while (idx < 6 && n < 1000) begin
      rdy = push_ready;
      tick; n++;
      if (rdy) begin
        idx++;
        push_data = 18'(idx + 1);
      end
      if (!push_ready && firstFull < 0) begin
        firstFull = idx;
        fullLevel = int'(level);
      end
    end
    push_valid = 1'b0;
    vecs++; if (idx != 6) begin errs++; $display("FAIL burst_accept: got %0d accepted expected 6", idx); end
    vecs++; if (firstFull != 5) begin errs++; $display("FAIL burst_full_count: got %0d expected 5", firstFull); end
    vecs++; if (fullLevel != 4) begin errs++; $display("FAIL burst_full_level: got %0d expected 4", fullLevel); end
    vecs++; if (level !== 3'd4) begin errs++; $display("FAIL burst_refill_level: got %0d expected 4", level); end
    n = 0;
    while (wrCyc.size() < base + 6 && n < 1500) begin tick; n++; end
    vecs++; if (wrCyc.size() != base + 6) begin errs++; $display("FAIL burst_writes: got %0d expected 6", wrCyc.size() - base); end
    if (wrCyc.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        vecs++;
        if (wrData[base+i] !== 18'(i + 1)) begin errs++; $display("FAIL burst_data%0d: got %h expected %h", i, wrData[base+i], 18'(i + 1)); end
      end
      for (int i = 1; i < 6; i++) begin
        vecs++;
        if (wrCyc[base+i] - wrCyc[base+i-1] != 162) begin errs++; $display("FAIL burst_spacing%0d: got %0d expected 162", i, wrCyc[base+i] - wrCyc[base+i-1]); end
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 300) begin tick; n++; end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL burst_drain: got busy %b expected 0", busy); end
  endtask

  task automatic run_dedup(input logic en, input int expWrites, input string tag);
    int base, n;
    base = wrCyc.size();
    dedup_en = en;
    push_valid = 1'b1; push_data = 18'h00010;
    repeat (3) tick;
    push_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 700) begin tick; n++; end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL %s_drain: got busy %b expected 0", tag, busy); end
    vecs++; if (wrCyc.size() - base != expWrites) begin errs++; $display("FAIL %s_count: got %0d expected %0d", tag, wrCyc.size() - base, expWrites); end
    vecs++; if (wrData[wrData.size()-1] !== 18'h00010) begin errs++; $display("FAIL %s_data: got %h expected 00010", tag, wrData[wrData.size()-1]); end
  endtask

  task automatic test_dedup;
    run_dedup(1'b1, 1, "dedup_on");
    run_dedup(1'b0, 3, "dedup_off");
  endtask

  task automatic test_midreset;
    int n, pulsesBefore, wbase;
    dedup_en = 1'b1;
    push_valid = 1'b1;
    push_data = 18'h00111; tick;
    push_data = 18'h00222; tick;
    push_data = 18'h00333; tick;
    push_valid = 1'b0;
    n = 0;
    while (lcd_write !== 1'b1 && n < 10) begin tick; n++; end
    vecs++; if (lcd_data !== 18'h00111) begin errs++; $display("FAIL mid_first_data: got %h expected 00111", lcd_data); end
    repeat (40) tick;
    vecs++; if (level !== 3'd2) begin errs++; $display("FAIL mid_queued: got %0d expected 2", level); end
    rst = 1'b1;
    tick;
    vecs++; if (level !== 3'd0) begin errs++; $display("FAIL mid_rst_level: got %0d expected 0", level); end
    vecs++; if (push_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready: got %b expected 0", push_ready); end
    pulsesBefore = rstPulses;
    wbase = wrCyc.size();
    rst = 1'b0;
    tick;
    vecs++; if (lcd_rst !== 1'b1) begin errs++; $display("FAIL mid_pulse: got %b expected 1", lcd_rst); end
    repeat (24) tick;
    vecs++; if (wrCyc.size() != wbase) begin errs++; $display("FAIL mid_no_write: got %0d writes expected 0", wrCyc.size() - wbase); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_idle: got busy %b expected 0", busy); end
    push_valid = 1'b1; push_data = 18'h00111;
    tick;
    push_valid = 1'b0;
    tick; tick;
    vecs++; if (lcd_write !== 1'b1) begin errs++; $display("FAIL mid_rewrite: got %b expected 1", lcd_write); end
    vecs++; if (lcd_data !== 18'h00111) begin errs++; $display("FAIL mid_rewrite_data: got %h expected 00111", lcd_data); end
    vecs++; if (rstPulses != pulsesBefore + 1) begin errs++; $display("FAIL mid_pulse_count: got %0d expected %0d", rstPulses, pulsesBefore + 1); end
    n = 0;
    while (busy !== 1'b0 && n < 300) begin tick; n++; end
  endtask

  task automatic test_mutex;
    vecs++; if (overlap != 0) begin errs++; $display("FAIL mutex: got %0d overlapping cycles expected 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_dedup();
    test_midreset();
    test_mutex();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lcd_value_feeder.md
Name: lcd_value_feeder

Overview:
- Upstream pacing stage for the 2x16 character LCD driver.
- Accepts 18-bit values from the processor side into a small FIFO.
- After power-up or reset, issues a one-shot LCD reset pulse and waits out the init sequence.
- Then presents one value at a time to the driver as a single-cycle write strobe, holding off each subsequent write until the driver has finished rendering.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- INIT_CYCLES, 24, clk cycles to wait after lcd_rst pulse before first write (>= driver init length).
- WRITE_CYCLES, 160, clk cycles to wait after each lcd_write pulse before the next (>= driver 18-bit render length).
- CNT_W, 8, width of hold-off counter; must hold max(INIT_CYCLES, WRITE_CYCLES).

Ports:
- clk  input  1  clock; all logic on rising edge; outputs registered so the driver samples them mid-cycle on its falling edge.
- rst  input  1  reset, synchronous, active-high.
- push_valid  input  1  producer has a value.
- push_data  input  18  value to display.
- push_ready  output  1  FIFO not full; transfer when push_valid & push_ready.
- dedup_en  input  1  when 1, skip values equal to the last value written.
- lcd_rst  output  1  one-cycle reset pulse to driver.
- lcd_write  output  1  one-cycle write strobe to driver.
- lcd_data  output  18  value presented to driver; stable from lcd_write through the end of HOLD.
- busy  output  1  high in any state other than IDLE, or when FIFO non-empty.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - state=INIT_RST, FIFO emptied (rd/wr ptr=0, level=0).
  - lcd_rst=0, lcd_write=0, lcd_data=0, last_valid=0, counter=0.
  - push_ready=0 while rst is high.
- FSM states and transitions:
  - INIT_RST: drive lcd_rst=1 for exactly one cycle -> INIT_WAIT with counter=INIT_CYCLES-1.
  - INIT_WAIT: decrement counter; at 0 -> IDLE. Pushes are accepted during init.
  - IDLE, FIFO empty: stay.
  - IDLE, FIFO non-empty, dedup_en=1, last_valid=1, head==last_value: pop head, no write, stay IDLE. One entry is discarded per cycle.
  - IDLE, FIFO non-empty, otherwise: pop head, lcd_data<=head, last_value<=head, last_valid<=1 -> ISSUE.
  - ISSUE: lcd_write=1 for exactly this one cycle -> HOLD with counter=WRITE_CYCLES-1.
  - HOLD: decrement counter; at 0 -> IDLE.
- Latency and throughput:
  - The earliest write after a push into an empty FIFO in IDLE: lcd_write is high 2 cycles after the push edge (pop edge, then ISSUE).
  - Minimum spacing between lcd_write rising edges is WRITE_CYCLES+2 cycles.
- FIFO:
  - push_ready = (level != DEPTH).
  - Simultaneous push and pop when full is not allowed: push_ready is already 0, so no write occurs.
  - Simultaneous push and pop when non-full: level unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - A push while full is ignored, with no corruption of stored data.
  - An empty FIFO never pops.
- Mutual exclusion: lcd_rst and lcd_write are never high in the same cycle. lcd_write is never high in INIT_*.
- Reset mid-operation (during HOLD or ISSUE):
  - Queued data is dropped.
  - A new lcd_rst pulse is issued the cycle after rst deasserts.
  - last_valid is cleared, so the first post-reset value is always written even when dedup_en=1.
- Counters: no arithmetic wrap. The counter loads only on state entry and decrements to 0 only.
- Busy: busy is 0 only in IDLE with level==0.

Test Plan:
- Power-up: rst high for 2 cycles, then low -> lcd_rst high exactly 1 cycle, then no lcd_write for 24 cycles, busy=1 throughout; after init, busy=0.
- Single push of 18'h2A5C5 in IDLE -> lcd_write high 1 cycle, 2 cycles after the push, with lcd_data=18'h2A5C5; lcd_data held for 160 more cycles; level returns to 0.
- Burst of 6 pushes (values 1..6), DEPTH=4:
  - push_ready drops after 4 entries are stored (5 once one pops).
  - All accepted values are written in order.
  - lcd_write edges are spaced exactly 162 cycles apart.
- dedup_en=1, push 18'h00010 three times -> exactly one lcd_write; with dedup_en=0 -> three writes.
- Reset asserted 40 cycles into HOLD with 2 entries queued -> level=0, one new lcd_rst pulse, no lcd_write until after INIT_CYCLES; the next push of a previously written value is still written.
- Push while full with push_valid held high -> contents are unchanged until a pop; the value is accepted on the cycle after level < DEPTH.
